// File: rtl/display_pkg.sv
// display_pkg: shared sizing helpers and board-clock timing defaults for display blocks
package display_pkg;
  localparam int DEF_DIV = 100000;
  localparam int DEF_BLANK = 1000;
  function automatic int clog2(int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int sel_w(int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/digit_scan_mux_if.sv
// digit_scan_mux_if: digit bus, mask and enable in, scanned digit and anode drive out
interface digit_scan_mux_if import display_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = sel_w(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] D;
  logic [CHANNELS-1:0] mask;
  logic en;
  logic [WIDTH-1:0] Y;
  logic [SEL_W-1:0] S;
  logic [CHANNELS-1:0] AN;
  logic blank;
  logic frame;
  modport master (output D, mask, en, input Y, S, AN, blank, frame);
  modport slave (input D, mask, en, output Y, S, AN, blank, frame);
endinterface

// File: rtl/digit_scan_mux_scan_next_sel.sv
// scan_next_sel: rotating-priority search for the next enabled channel above cur
module scan_next_sel #(
  parameter int CHANNELS = 4,
  parameter int SEL_W = 2
) (
  input logic [CHANNELS-1:0] mask,
  input logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic wrap
);
  int idx;
  logic found;
  // i == CHANNELS lands back on cur, so a lone enabled channel re-selects itself and wraps
  always_comb begin
    nxt = cur;
    wrap = 1'b0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(cur) + i) % CHANNELS;
      if (!found && mask[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        nxt = idx[SEL_W-1:0];
        wrap = idx <= int'(cur);
      end
    end
  end
endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed digit scanner with per-slot blanking and channel mask
module digit_scan_mux import display_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int DIV = DEF_DIV,
  parameter int BLANK = DEF_BLANK
) (
  input logic clk,
  input logic rst_n,
  digit_scan_mux_if.slave bus
);
  localparam int SEL_W = sel_w(CHANNELS);
  localparam int CW = clog2(DIV);
  logic [CW-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] nxt, s_n;
  logic wrap, last, adv, lit;
  scan_next_sel #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_sel (
    .mask(bus.mask),
    .cur(bus.S),
    .nxt(nxt),
    .wrap(wrap)
  );
  // outputs are registered from next-state values so AN, Y and S always describe the same cycle
  always_comb begin
    last = cnt == CW'(DIV - 1);
    adv = bus.en && last;
    cnt_n = !bus.en ? cnt : last ? '0 : cnt + CW'(1);
    s_n = adv ? nxt : bus.S;
    lit = bus.en && cnt_n >= CW'(BLANK) && bus.mask[s_n];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      bus.S <= '0;
      bus.Y <= '0;
      bus.AN <= '1;
      bus.blank <= 1'b1;
      bus.frame <= 1'b0;
    end else begin
      cnt <= cnt_n;
      bus.S <= s_n;
      bus.Y <= bus.D[int'(s_n)*WIDTH +: WIDTH];
      bus.AN <= lit ? ~(CHANNELS'(1) << s_n) : '1;
      bus.blank <= !lit;
      bus.frame <= adv && wrap;
    end
  end
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed scenarios for the digit scanner at DIV=8, BLANK=2
module tb_digit_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [3:0] dig [4] = '{4'h9, 4'h5, 4'h2, 4'h1};
  digit_scan_mux_if #(.WIDTH(4), .CHANNELS(4)) bus ();
  digit_scan_mux #(.WIDTH(4), .CHANNELS(4), .DIV(8), .BLANK(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] m);
    bus.mask = m;
    bus.en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] an_on(input int s);
    logic [3:0] one;
    one = 4'h1;
    return 4'hF ^ (one << s);
  endfunction

  task automatic test_reset;
    bus.mask = 4'hF;
    bus.en = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.S, bus.Y, bus.AN, bus.blank, bus.frame} !== {2'd0, 4'h0, 4'hF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset: S=%0d Y=%h AN=%b blank=%b frame=%b, want S=0 Y=0 AN=1111 blank=1 frame=0",
               bus.S, bus.Y, bus.AN, bus.blank, bus.frame);
    end
  endtask

  task automatic test_scan_all;
    logic [3:0] e_an;
    int s, c;
    do_reset(4'hF);
    for (int k = 1; k < 72; k++) begin
      tick();
      s = (k / 8) % 4;
      c = k % 8;
      e_an = c >= 2 ? an_on(s) : 4'hF;
      total++;
      if (bus.S !== 2'(s) || bus.Y !== dig[s] || bus.AN !== e_an || bus.blank !== (e_an == 4'hF)
          || bus.frame !== (k % 32 == 0)) begin
        bad++;
        $display("FAIL scan_all k=%0d: S=%0d Y=%h AN=%b blank=%b frame=%b, want S=%0d Y=%h AN=%b frame=%b",
                 k, bus.S, bus.Y, bus.AN, bus.blank, bus.frame, s, dig[s], e_an, k % 32 == 0);
      end
    end
  endtask

  task automatic test_leading_suppress;
    logic [3:0] e_an;
    int s, c;
    do_reset(4'b0111);
    for (int k = 1; k < 56; k++) begin
      tick();
      s = (k / 8) % 3;
      c = k % 8;
      e_an = c >= 2 ? an_on(s) : 4'hF;
      total++;
      if (bus.S !== 2'(s) || bus.Y !== dig[s] || bus.AN !== e_an || bus.frame !== (k % 24 == 0)) begin
        bad++;
        $display("FAIL leading k=%0d: S=%0d Y=%h AN=%b frame=%b, want S=%0d Y=%h AN=%b frame=%b",
                 k, bus.S, bus.Y, bus.AN, bus.frame, s, dig[s], e_an, k % 24 == 0);
      end
    end
  endtask

  task automatic test_mask_mid_slot;
    do_reset(4'hF);
    repeat (12) tick();
    total++;
    if (bus.S !== 2'd1 || bus.AN !== 4'b1101) begin
      bad++;
      $display("FAIL mask_mid pre: S=%0d AN=%b, want S=1 AN=1101", bus.S, bus.AN);
    end
    bus.mask = 4'b1101;
    for (int k = 13; k < 16; k++) begin
      tick();
      total++;
      if (bus.S !== 2'd1 || bus.AN !== 4'hF || bus.blank !== 1'b1) begin
        bad++;
        $display("FAIL mask_mid hold k=%0d: S=%0d AN=%b blank=%b, want S=1 AN=1111 blank=1",
                 k, bus.S, bus.AN, bus.blank);
      end
    end
    tick();
    total++;
    if (bus.S !== 2'd2 || bus.Y !== 4'h2) begin
      bad++;
      $display("FAIL mask_mid advance: S=%0d Y=%h, want S=2 Y=2", bus.S, bus.Y);
    end
    repeat (2) tick();
    total++;
    if (bus.AN !== 4'b1011) begin
      bad++;
      $display("FAIL mask_mid slot2 AN=%b, want 1011", bus.AN);
    end
    repeat (14) tick();
    total++;
    if (bus.S !== 2'd0 || bus.frame !== 1'b1) begin
      bad++;
      $display("FAIL mask_mid wrap: S=%0d frame=%b, want S=0 frame=1", bus.S, bus.frame);
    end
    repeat (8) tick();
    total++;
    if (bus.S !== 2'd2 || bus.frame !== 1'b0) begin
      bad++;
      $display("FAIL mask_mid skip: S=%0d frame=%b, want S=2 frame=0", bus.S, bus.frame);
    end
  endtask

  task automatic test_en_pause;
    do_reset(4'hF);
    repeat (5) tick();
    bus.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (bus.S !== 2'd0 || bus.AN !== 4'hF || bus.blank !== 1'b1 || bus.frame !== 1'b0) begin
        bad++;
        $display("FAIL en_pause k=%0d: S=%0d AN=%b blank=%b frame=%b, want S=0 AN=1111 blank=1 frame=0",
                 k, bus.S, bus.AN, bus.blank, bus.frame);
      end
    end
    bus.en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (bus.S !== 2'd0 || bus.AN !== 4'b1110) begin
        bad++;
        $display("FAIL en_resume k=%0d: S=%0d AN=%b, want S=0 AN=1110", k, bus.S, bus.AN);
      end
    end
    tick();
    total++;
    if (bus.S !== 2'd1 || bus.AN !== 4'hF || bus.Y !== 4'h5) begin
      bad++;
      $display("FAIL en_resume advance: S=%0d AN=%b Y=%h, want S=1 AN=1111 Y=5", bus.S, bus.AN, bus.Y);
    end
  endtask

  task automatic test_mask_zero;
    do_reset(4'h0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      total++;
      if (bus.S !== 2'd0 || bus.AN !== 4'hF || bus.blank !== 1'b1 || bus.frame !== 1'b0) begin
        bad++;
        $display("FAIL mask_zero k=%0d: S=%0d AN=%b blank=%b frame=%b, want S=0 AN=1111 blank=1 frame=0",
                 k, bus.S, bus.AN, bus.blank, bus.frame);
      end
    end
  endtask

  task automatic test_reset_mid_slot;
    do_reset(4'hF);
    repeat (22) tick();
    total++;
    if (bus.S !== 2'd2 || bus.AN !== 4'b1011) begin
      bad++;
      $display("FAIL rst_mid pre: S=%0d AN=%b, want S=2 AN=1011", bus.S, bus.AN);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({bus.S, bus.Y, bus.AN, bus.blank, bus.frame} !== {2'd0, 4'h0, 4'hF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid: S=%0d Y=%h AN=%b blank=%b frame=%b, want S=0 Y=0 AN=1111 blank=1 frame=0",
               bus.S, bus.Y, bus.AN, bus.blank, bus.frame);
    end
    tick();
    total++;
    if (bus.AN !== 4'hF || bus.Y !== 4'h9) begin
      bad++;
      $display("FAIL rst_mid cnt1: AN=%b Y=%h, want AN=1111 Y=9", bus.AN, bus.Y);
    end
    tick();
    total++;
    if (bus.AN !== 4'b1110 || bus.S !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid cnt2: AN=%b S=%0d, want AN=1110 S=0", bus.AN, bus.S);
    end
  endtask

  initial begin
    bus.D = {4'h1, 4'h2, 4'h5, 4'h9};
    bus.mask = 4'hF;
    bus.en = 1'b1;
    test_reset();
    test_scan_all();
    test_leading_suppress();
    test_mask_mid_slot();
    test_en_pause();
    test_mask_zero();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
